// File: rtl/bf_pkg.sv
// Shared types and constants for the Brainfuck program store: opcodes,
// loader states, source-character codes and the character decoder.
package bf_pkg;

  localparam int          BF_ADDR_W = 12;
  localparam int          BF_DATA_W = 4;
  localparam logic [11:0] MAX_ADDR  = 12'h999;

  typedef enum logic [3:0] {
    OP_HALT  = 4'h0,
    OP_INC   = 4'h2,
    OP_DEC   = 4'h3,
    OP_RIGHT = 4'h4,
    OP_LEFT  = 4'h5,
    OP_LOOP  = 4'h6,
    OP_END   = 4'h7,
    OP_OUT   = 4'h8,
    OP_IN    = 4'h9
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_TERM  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_t;

  localparam logic [7:0] CH_INC   = 8'h2B;
  localparam logic [7:0] CH_DEC   = 8'h2D;
  localparam logic [7:0] CH_RIGHT = 8'h3E;
  localparam logic [7:0] CH_LEFT  = 8'h3C;
  localparam logic [7:0] CH_LOOP  = 8'h5B;
  localparam logic [7:0] CH_END   = 8'h5D;
  localparam logic [7:0] CH_OUT   = 8'h2E;
  localparam logic [7:0] CH_IN    = 8'h2C;
  localparam logic [7:0] CH_NUL   = 8'h00;
  localparam logic [7:0] CH_EOT   = 8'h04;

  typedef struct packed {
    logic    is_cmd;
    opcode_t op;
  } decode_t;

  function automatic decode_t decode_char(input logic [7:0] c);
    decode_t d;
    d.is_cmd = 1'b1;
    d.op     = OP_HALT;
    case (c)
      CH_INC:   d.op = OP_INC;
      CH_DEC:   d.op = OP_DEC;
      CH_RIGHT: d.op = OP_RIGHT;
      CH_LEFT:  d.op = OP_LEFT;
      CH_LOOP:  d.op = OP_LOOP;
      CH_END:   d.op = OP_END;
      CH_OUT:   d.op = OP_OUT;
      CH_IN:    d.op = OP_IN;
      default:  d.is_cmd = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == CH_NUL) || (c == CH_EOT);
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD counter with synchronous clear and increment; saturates at
// MAX_VAL and flags when it is there.
module bcd_counter3 #(
  parameter logic [11:0] MAX_VAL = bf_pkg::MAX_ADDR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [11:0] value_o,
  output logic        at_max_o
);

  logic [11:0] cnt_q, cnt_d;

  assign value_o  = cnt_q;
  assign at_max_o = (cnt_q == MAX_VAL);

  // Each digit wraps 9 -> 0 and carries into the next one up.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 12'h000;
    end else if (inc_i && !at_max_o) begin
      if (cnt_q[3:0] == 4'd9) begin
        cnt_d[3:0] = 4'd0;
        if (cnt_q[7:4] == 4'd9) begin
          cnt_d[7:4]  = 4'd0;
          cnt_d[11:8] = cnt_q[11:8] + 4'd1;
        end else begin
          cnt_d[7:4] = cnt_q[7:4] + 4'd1;
        end
      end else begin
        cnt_d[3:0] = cnt_q[3:0] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= 12'h000;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bf_program_loader.sv
// Encodes an ASCII Brainfuck source stream into 4-bit opcodes written at BCD
// addresses from 000, ending with a halt. Optional: BF_LOADER_BRACKET_CHECK_EN.
module bf_program_loader #(
  parameter int          ADDR_W   = bf_pkg::BF_ADDR_W,
  parameter int          DATA_W   = bf_pkg::BF_DATA_W,
  parameter logic [11:0] MAX_ADDR = bf_pkg::MAX_ADDR
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [7:0]        In_Data,
  input  logic              In_Valid,
  output logic              In_Ready,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Data,
  output logic              Mem_We,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W-1:0] Length
);
  import bf_pkg::*;

  loader_state_t     state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cnt_clr, cnt_inc, cnt_at_max;
  logic [11:0]       cnt_value;
  logic              accept;
  logic              fault;
  decode_t           dec;

`ifdef BF_LOADER_BRACKET_CHECK_EN
  logic [7:0] depth_q, depth_d;
`endif

  bcd_counter3 #(.MAX_VAL(MAX_ADDR)) u_addr_cnt (
    .clk_i    (Clk),
    .rst_i    (Rst),
    .clr_i    (cnt_clr),
    .inc_i    (cnt_inc),
    .value_o  (cnt_value),
    .at_max_o (cnt_at_max)
  );

  assign dec      = decode_char(In_Data);
  assign accept   = (state_q == ST_LOAD) && In_Valid;
  assign In_Ready = (state_q == ST_LOAD);
  assign Busy     = (state_q == ST_LOAD) || (state_q == ST_TERM);
  assign Mem_We   = we_q;
  assign Mem_Addr = addr_q;
  assign Mem_Data = data_q;
  assign Done     = done_q;
  assign Error    = err_q;
  assign Length   = ADDR_W'(cnt_value);

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;
    err_d   = err_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    fault   = 1'b0;
`ifdef BF_LOADER_BRACKET_CHECK_EN
    depth_d = depth_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (Start) begin
          state_d = ST_LOAD;
          cnt_clr = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
`ifdef BF_LOADER_BRACKET_CHECK_EN
          depth_d = 8'd0;
`endif
        end
      end
      ST_LOAD: begin
        if (accept && is_term(In_Data)) begin
`ifdef BF_LOADER_BRACKET_CHECK_EN
          fault = (depth_q != 8'd0);
`endif
          if (fault) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_TERM;
            we_d    = 1'b1;
            addr_d  = ADDR_W'(cnt_value);
            data_d  = DATA_W'(OP_HALT);
          end
        end else if (accept && dec.is_cmd) begin
          // Address 999 is reserved for the halt, so a command there overflows.
          fault = cnt_at_max;
`ifdef BF_LOADER_BRACKET_CHECK_EN
          fault = fault || (dec.op == OP_END && depth_q == 8'd0)
                        || (dec.op == OP_LOOP && depth_q == 8'hFF);
`endif
          if (fault) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            we_d    = 1'b1;
            addr_d  = ADDR_W'(cnt_value);
            data_d  = DATA_W'(dec.op);
            cnt_inc = 1'b1;
`ifdef BF_LOADER_BRACKET_CHECK_EN
            if (dec.op == OP_LOOP) depth_d = depth_q + 8'd1;
            if (dec.op == OP_END)  depth_d = depth_q - 8'd1;
`endif
          end
        end
      end
      ST_TERM: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BF_LOADER_BRACKET_CHECK_EN
      depth_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef BF_LOADER_BRACKET_CHECK_EN
      depth_q <= depth_d;
`endif
    end
  end

endmodule

// File: tb/tb_bf_program_loader.sv
// Bench for bf_program_loader: directed and random source streams checked
// against a character-level model of the expected memory writes.
module tb_bf_program_loader;

  logic        Clk = 1'b0;
  logic        Rst, Start, In_Valid;
  logic [7:0]  In_Data;
  logic        In_Ready, Mem_We, Busy, Done, Error;
  logic [11:0] Mem_Addr, Length;
  logic [3:0]  Mem_Data;

  int nCmp  = 0;
  int nFail = 0;

  logic [7:0]  stim[$];
  logic [15:0] wlog[$];
  logic [15:0] expW[$];
  bit          expWe[$];
  int          expConsumed;
  bit          expDone, expErr;
  logic [11:0] expLen;

  bf_program_loader dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .In_Data(In_Data), .In_Valid(In_Valid),
    .In_Ready(In_Ready), .Mem_Addr(Mem_Addr), .Mem_Data(Mem_Data), .Mem_We(Mem_We),
    .Busy(Busy), .Done(Done), .Error(Error), .Length(Length)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (!Rst && Mem_We) wlog.push_back({Mem_Addr, Mem_Data});
  end

  function automatic int opOf(input logic [7:0] c);
    string cmds = "+-><[].,";
    for (int i = 0; i < 8; i++) if (c == cmds[i]) return i + 2;
    return -1;
  endfunction

  function automatic logic [11:0] toBcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Walks the byte stream character by character, tracking the plain opcode count.
  task automatic modelRun();
    int n = 0;
    int depth = 0;
    int op;
    expW.delete(); expWe.delete();
    expConsumed = 0; expDone = 0; expErr = 0;
    foreach (stim[i]) begin
      expConsumed++;
      if (stim[i] == 8'h00 || stim[i] == 8'h04) begin
`ifdef BF_LOADER_BRACKET_CHECK_EN
        if (depth != 0) begin expErr = 1; expWe.push_back(0); break; end
`endif
        expW.push_back({toBcd(n), 4'h0}); expWe.push_back(1); expDone = 1;
        break;
      end
      op = opOf(stim[i]);
      if (op < 0) begin expWe.push_back(0); continue; end
      if (n == 999) begin expErr = 1; expWe.push_back(0); break; end
`ifdef BF_LOADER_BRACKET_CHECK_EN
      if ((op == 7 && depth == 0) || (op == 6 && depth == 255)) begin
        expErr = 1; expWe.push_back(0); break;
      end
      if (op == 6) depth++;
      if (op == 7) depth--;
`endif
      expW.push_back({toBcd(n), 4'(op)}); expWe.push_back(1);
      n++;
    end
    expLen = toBcd(n);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    nCmp++; nFail++;
    $error("[TB] FAIL %s: observed timeout expected completion", tag);
  endtask

  task automatic pushByte(input logic [7:0] b, input int stall);
    int guard = 0;
    repeat (stall) begin In_Valid = 1'b0; @(posedge Clk); #1; end
    In_Data = b; In_Valid = 1'b1;
    while (!In_Ready && guard < 50) begin @(posedge Clk); #1; guard++; end
    if (guard >= 50) timeoutFail("in_ready wait");
    @(posedge Clk); #1;
    In_Valid = 1'b0;
  endtask

  task automatic addText(input string s);
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  task automatic applyStimulus(input string name, input int maxStall);
    int g = 0;
    int nCheck;
    modelRun();
    wlog.delete();
    Start = 1'b1; @(posedge Clk); #1; Start = 1'b0;
    checkOutput({name, " ready"}, In_Ready, 1);
    checkOutput({name, " len0"}, Length, 0);
    for (int i = 0; i < expConsumed; i++) begin
      pushByte(stim[i], maxStall > 0 ? int'($urandom_range(0, maxStall)) : 0);
      checkOutput($sformatf("%s we[%0d]", name, i), Mem_We, expWe[i]);
    end
    while (Busy && g < 20) begin @(posedge Clk); #1; g++; end
    if (g >= 20) timeoutFail({name, " busy"});
    repeat (2) @(posedge Clk);
    #1;
    checkOutput({name, " nwrites"}, wlog.size(), expW.size());
    nCheck = (wlog.size() < expW.size()) ? wlog.size() : expW.size();
    for (int i = 0; i < nCheck; i++)
      checkOutput($sformatf("%s write[%0d]", name, i), wlog[i], expW[i]);
    checkOutput({name, " done"}, Done, expDone);
    checkOutput({name, " error"}, Error, expErr);
    checkOutput({name, " length"}, Length, expLen);
    checkOutput({name, " busy"}, Busy, 0);
    checkOutput({name, " ready_off"}, In_Ready, 0);
  endtask

  initial begin
    string alpha;
    logic [7:0] saved[$];
    Rst = 1'b1; Start = 1'b0; In_Valid = 1'b0; In_Data = 8'h00;
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("rst ready", In_Ready, 0);
    checkOutput("rst we", Mem_We, 0);
    checkOutput("rst addr", Mem_Addr, 0);
    checkOutput("rst data", Mem_Data, 0);
    checkOutput("rst busy", Busy, 0);
    checkOutput("rst done", Done, 0);
    checkOutput("rst error", Error, 0);
    checkOutput("rst length", Length, 0);
    Rst = 1'b0;
    @(posedge Clk); #1;

    stim.delete(); addText("+-><[].,"); stim.push_back(8'h00);
    applyStimulus("allcmds", 0);

    stim.delete(); addText("a+\n+ "); stim.push_back(8'h04);
    applyStimulus("filter", 0);

    stim.delete(); repeat (12) stim.push_back("+"); stim.push_back(8'h00);
    applyStimulus("carry", 0);

    stim.delete(); repeat (1000) stim.push_back("+");
    applyStimulus("overflow", 0);

    stim.delete(); repeat (999) stim.push_back("+"); stim.push_back(8'h00);
    applyStimulus("full", 0);

    stim.delete(); addText("]+"); stim.push_back(8'h00);
    applyStimulus("close_first", 0);

    stim.delete(); addText("[+"); stim.push_back(8'h00);
    applyStimulus("open_unclosed", 0);

    alpha = "+-><[].,ax \n";
    for (int r = 0; r < 3; r++) begin
      stim.delete();
      repeat ($urandom_range(1, 40)) stim.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
      stim.push_back(($urandom_range(0, 1) != 0) ? 8'h04 : 8'h00);
      saved = stim;
      applyStimulus($sformatf("rand%0d", r), 0);
      stim = saved;
      applyStimulus($sformatf("rand%0d_stall", r), 3);
    end

    // Reset in the middle of a load must silence the loader at once.
    Start = 1'b1; @(posedge Clk); #1; Start = 1'b0;
    pushByte("+", 0); pushByte("+", 0);
    In_Data = "+"; In_Valid = 1'b1; Rst = 1'b1;
    @(posedge Clk); #1;
    checkOutput("midrst we", Mem_We, 0);
    checkOutput("midrst ready", In_Ready, 0);
    checkOutput("midrst busy", Busy, 0);
    checkOutput("midrst length", Length, 0);
    checkOutput("midrst addr", Mem_Addr, 0);
    checkOutput("midrst data", Mem_Data, 0);
    Rst = 1'b0;
    wlog.delete();
    repeat (5) @(posedge Clk);
    #1;
    checkOutput("midrst nowrites", wlog.size(), 0);
    checkOutput("midrst idle_ready", In_Ready, 0);
    In_Valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
